ram_rd_arbiter: RTL

//  Shares the single read port of the simulation RAM between two requesters (m0, m1, e.g. I-fetch
//  and D-load). Round-robin arbitration, one outstanding read at a time. Latches the winner's

---
 rtl/ram_rd_if.sv | 18 +
 rtl/ram_rd_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/ram_rd_if.sv
// Read-channel bundle (AR + R) between a requester and a read port.
// master drives the request and R-ready; slave answers with AR-ready and read data.
interface ram_rd_if #(
  parameter int DW = 128,
  parameter int AW = 16
);
  logic          arValid;
  logic          arReady;
  logic [AW-1:0] arAddr;
  logic          rValid;
  logic          rReady;
  logic [DW-1:0] rData;

  modport master (output arValid, arAddr, rReady,
                  input  arReady, rValid, rData);
  modport slave  (input  arValid, arAddr, rReady,
                  output arReady, rValid, rData);
endinterface

// File: rtl/ram_rd_arbiter.sv
// Round-robin arbiter sharing the RAM read port between two requesters.
// Only one read is in flight at a time: accept, issue AR, route R back to the winner.
module ram_rd_arbiter #(
  parameter int DW = 128,
  parameter int AW = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  ram_rd_if.slave  m0,
  ram_rd_if.slave  m1,
  ram_rd_if.master s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          win;
  logic          m0_ar_rdy, m1_ar_rdy;
  logic          m0_rv, m1_rv;
  logic [DW-1:0] m0_rd, m1_rd;
  logic          s_arv, s_rrdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    win       = 1'b0;
    m0_ar_rdy = 1'b0;
    m1_ar_rdy = 1'b0;
    m0_rv     = 1'b0;
    m1_rv     = 1'b0;
    m0_rd     = '0;
    m1_rd     = '0;
    s_arv     = 1'b0;
    s_rrdy    = 1'b0;

    case (state_q)
      IDLE: begin
        // rr_q breaks ties; a lone requester wins regardless of the pointer
        win = (m0.arValid && m1.arValid) ? rr_q : m1.arValid;
        if (m0.arValid || m1.arValid) begin
          m0_ar_rdy = ~win;
          m1_ar_rdy = win;
          addr_d    = win ? m1.arAddr : m0.arAddr;
          grant_d   = win;
          rr_d      = ~win;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        s_arv = 1'b1;
        if (s.arReady) state_d = DATA;
      end
      DATA: begin
        if (grant_q) begin
          m1_rv  = s.rValid;
          m1_rd  = s.rData;
          s_rrdy = m1.rReady;
        end else begin
          m0_rv  = s.rValid;
          m0_rd  = s.rData;
          s_rrdy = m0.rReady;
        end
        if (s.rValid && s_rrdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are forced low for the whole reset window, not just after the first edge
  assign m0.arReady = rst_n & m0_ar_rdy;
  assign m1.arReady = rst_n & m1_ar_rdy;
  assign m0.rValid  = rst_n & m0_rv;
  assign m1.rValid  = rst_n & m1_rv;
  assign m0.rData   = m0_rd;
  assign m1.rData   = m1_rd;
  assign s.arValid  = rst_n & s_arv;
  assign s.arAddr   = addr_q;
  assign s.rReady   = rst_n & s_rrdy;

endmodule
